// File: rtl/vai_rx_pkg.sv
// Shared types for the virtualised-AFU Rx demux: a reduced CCI-P Rx
// bundle, control register indices and the per-channel decode record.
package vai_rx_pkg;

    localparam int REG_ENABLE      = 4;
    localparam int REG_DROP_CLR    = 5;
    localparam int REG_OFFSET_BASE = 8;

    typedef struct packed {
        logic [8:0]  tid;
        logic [1:0]  len;
        logic [15:0] addr;
        logic [15:0] mdata;
    } t_c0_hdr;

    typedef struct packed {
        logic [15:0] mdata;
    } t_c1_hdr;

    typedef struct packed {
        t_c0_hdr     hdr;
        logic [63:0] data;
        logic        rspValid;
        logic        mmioRdValid;
        logic        mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_c1_hdr hdr;
        logic    rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [15:0] vmid;
        logic        is_ctl;
        logic        is_drop;
        logic        to_mgr;
    } t_vai_rx_decode;

    function automatic logic [15:0] vmid_extract(
        input logic [15:0] mdata,
        input int          msb,
        input int          width
    );
        logic [15:0] mask;
        mask = (16'd1 << width) - 16'd1;
        return (mdata >> (msb - width + 1)) & mask;
    endfunction

endpackage

// File: rtl/vai_rx_ctl_regs.sv
// Per-VM offset registers, VM enable mask and saturating drop counter,
// written from the decode stage of the Rx demux.
module vai_rx_ctl_regs
    import vai_rx_pkg::*;
#(
    parameter int                      NUM_SUB_AFUS = 8,
    parameter logic [NUM_SUB_AFUS-1:0] ENABLE_RESET = '1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en_i,
    input  logic [15:0]             wr_idx_i,
    input  logic [63:0]             wr_data_i,
    input  logic [1:0]              drop_inc_i,
    output logic [63:0]             offset_o [NUM_SUB_AFUS],
    output logic [NUM_SUB_AFUS-1:0] enable_o,
    output logic [31:0]             drop_count_o
);

    logic [63:0]             offset_q [NUM_SUB_AFUS];
    logic [63:0]             offset_d [NUM_SUB_AFUS];
    logic [NUM_SUB_AFUS-1:0] enable_q, enable_d;
    logic [31:0]             drop_q, drop_d;
    logic [32:0]             drop_sum;

    always_comb begin
        offset_d = offset_q;
        enable_d = enable_q;
        drop_sum = {1'b0, drop_q} + 33'(drop_inc_i);
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
        // A clear in the same cycle as a drop leaves the counter at zero.
        if (wr_en_i) begin
            if (wr_idx_i == 16'(REG_ENABLE)) begin
                enable_d = wr_data_i[NUM_SUB_AFUS-1:0];
            end
            if (wr_idx_i == 16'(REG_DROP_CLR)) begin
                drop_d = '0;
            end
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                if (wr_idx_i == 16'(REG_OFFSET_BASE + i)) begin
                    offset_d[i] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                offset_q[i] <= '0;
            end
            enable_q <= ENABLE_RESET;
            drop_q   <= '0;
        end else begin
            offset_q <= offset_d;
            enable_q <= enable_d;
            drop_q   <= drop_d;
        end
    end

    assign offset_o     = offset_q;
    assign enable_o     = enable_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/vai_rx_demux.sv
// CCI-P Rx demultiplexer: routes responses by mdata VMID and MMIO by
// address window to sub-AFU ports or the manager port.
module vai_rx_demux
    import vai_rx_pkg::*;
#(
    parameter int                      NUM_SUB_AFUS    = 8,
    parameter int                      VMID_MSB        = 15,
    parameter int                      MMIO_WIN_LOG2   = 6,
    parameter int                      NUM_PIPE_STAGES = 0,
    parameter logic [NUM_SUB_AFUS-1:0] ENABLE_RESET    = '1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  t_if_ccip_Rx             up_RxPort,
    output t_if_ccip_Rx             afu_RxPort [NUM_SUB_AFUS],
    output t_if_ccip_Rx             mgr_RxPort,
    output logic [63:0]             offset_array [NUM_SUB_AFUS],
    output logic [NUM_SUB_AFUS-1:0] vm_enable,
    output logic [31:0]             drop_count
);

    localparam int          VMID_WIDTH = $clog2(NUM_SUB_AFUS);
    localparam logic [15:0] VMID_MASK  =
        16'(((1 << VMID_WIDTH) - 1) << (VMID_MSB - VMID_WIDTH + 1));
    localparam logic [15:0] WIN_MASK   = 16'(32'hFFFF << MMIO_WIN_LOG2);

    if (8 + NUM_SUB_AFUS > 2 ** (MMIO_WIN_LOG2 - 1)) begin : g_bad_win
        $error("control window too small for offset registers");
    end

    function automatic logic vm_ok(
        input logic [15:0]             vm,
        input logic [NUM_SUB_AFUS-1:0] en
    );
        return (vm < 16'(NUM_SUB_AFUS)) && en[vm[VMID_WIDTH-1:0]];
    endfunction

    t_if_ccip_Rx    pipe_q [NUM_PIPE_STAGES+1];
    t_if_ccip_Rx    s1, s2_d, s2_q;
    t_vai_rx_decode dec0_d, dec1_d, dec0_q, dec1_q;
    t_if_ccip_Rx    afu_d [NUM_SUB_AFUS];
    t_if_ccip_Rx    afu_q [NUM_SUB_AFUS];
    t_if_ccip_Rx    mgr_d, mgr_q;
    logic [15:0]    win, mmio_vm, reg_idx;
    logic           c0_mmio, ctl_wr, fwd0, fwd1;
    logic [1:0]     drop_inc;

    // The last element of the input pipe is S1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= NUM_PIPE_STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= up_RxPort;
            for (int k = 1; k <= NUM_PIPE_STAGES; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign s1      = pipe_q[NUM_PIPE_STAGES];
    assign win     = s1.c0.hdr.addr >> MMIO_WIN_LOG2;
    assign mmio_vm = win - 16'd1;
    assign reg_idx = (s1.c0.hdr.addr & ~WIN_MASK) >> 1;
    assign c0_mmio = s1.c0.mmioRdValid | s1.c0.mmioWrValid;
    assign ctl_wr  = s1.c0.mmioWrValid && (win == '0);

    always_comb begin
        s2_d   = s1;
        dec0_d = '0;
        dec1_d = '0;
        if (s1.c0.rspValid) begin
            dec0_d.vmid    = vmid_extract(s1.c0.hdr.mdata, VMID_MSB, VMID_WIDTH);
            dec0_d.is_drop = !vm_ok(dec0_d.vmid, vm_enable);
            s2_d.c0.hdr.mdata = s1.c0.hdr.mdata & ~VMID_MASK;
        end else if (c0_mmio) begin
            if (win == '0) begin
                dec0_d.is_ctl = 1'b1;
                dec0_d.to_mgr = 1'b1;
                s2_d.c0.hdr.addr = s1.c0.hdr.addr & ~WIN_MASK;
            end else if (vm_ok(mmio_vm, vm_enable)) begin
                dec0_d.vmid = mmio_vm;
                s2_d.c0.hdr.addr = s1.c0.hdr.addr & ~WIN_MASK;
            end else if (s1.c0.mmioRdValid) begin
                dec0_d.to_mgr = 1'b1;
            end else begin
                dec0_d.is_drop = 1'b1;
            end
        end
        if (s1.c1.rspValid) begin
            dec1_d.vmid    = vmid_extract(s1.c1.hdr.mdata, VMID_MSB, VMID_WIDTH);
            dec1_d.is_drop = !vm_ok(dec1_d.vmid, vm_enable);
            s2_d.c1.hdr.mdata = s1.c1.hdr.mdata & ~VMID_MASK;
        end
    end

    assign drop_inc = {1'b0, dec0_d.is_drop} + {1'b0, dec1_d.is_drop};

    vai_rx_ctl_regs #(
        .NUM_SUB_AFUS (NUM_SUB_AFUS),
        .ENABLE_RESET (ENABLE_RESET)
    ) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en_i      (ctl_wr),
        .wr_idx_i     (reg_idx),
        .wr_data_i    (s1.c0.data),
        .drop_inc_i   (drop_inc),
        .offset_o     (offset_array),
        .enable_o     (vm_enable),
        .drop_count_o (drop_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_q   <= '0;
            dec0_q <= '0;
            dec1_q <= '0;
        end else begin
            s2_q   <= s2_d;
            dec0_q <= dec0_d;
            dec1_q <= dec1_d;
        end
    end

    assign fwd0 = (s2_q.c0.rspValid | s2_q.c0.mmioRdValid | s2_q.c0.mmioWrValid)
                  && !dec0_q.is_drop && !dec0_q.to_mgr && !dec0_q.is_ctl;
    assign fwd1 = s2_q.c1.rspValid
                  && !dec1_q.is_drop && !dec1_q.to_mgr && !dec1_q.is_ctl;

    always_comb begin
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            afu_d[i] = '0;
            if (fwd0 && dec0_q.vmid == 16'(i)) afu_d[i].c0 = s2_q.c0;
            if (fwd1 && dec1_q.vmid == 16'(i)) afu_d[i].c1 = s2_q.c1;
        end
        mgr_d = '0;
        if (dec0_q.to_mgr) mgr_d.c0 = s2_q.c0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                afu_q[i] <= '0;
            end
            mgr_q <= '0;
        end else begin
            afu_q <= afu_d;
            mgr_q <= mgr_d;
        end
    end

    assign afu_RxPort = afu_q;
    assign mgr_RxPort = mgr_q;

endmodule

// File: tb/tb_vai_rx_demux.sv
// Directed bench for vai_rx_demux: expected port outputs are queued per
// cycle when stimulus is driven and compared when they fall due.
module tb_vai_rx_demux;
    import vai_rx_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    t_if_ccip_Rx up_a, up_b, mgr_a, mgr_b;
    t_if_ccip_Rx afu_a [N];
    t_if_ccip_Rx afu_b [N];
    logic [63:0] off_a [N];
    logic [63:0] off_b [N];
    logic [N-1:0] en_a, en_b;
    logic [31:0] drop_a, drop_b;

    vai_rx_demux #(.NUM_SUB_AFUS(N)) u_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .up_RxPort    (up_a),
        .afu_RxPort   (afu_a),
        .mgr_RxPort   (mgr_a),
        .offset_array (off_a),
        .vm_enable    (en_a),
        .drop_count   (drop_a)
    );

    vai_rx_demux #(
        .NUM_SUB_AFUS    (N),
        .MMIO_WIN_LOG2   (8),
        .NUM_PIPE_STAGES (2)
    ) u_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .up_RxPort    (up_b),
        .afu_RxPort   (afu_b),
        .mgr_RxPort   (mgr_b),
        .offset_array (off_b),
        .vm_enable    (en_b),
        .drop_count   (drop_b)
    );

    typedef struct {
        int             cyc;
        int             dut;
        int             port;
        bit             ch;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_exp;

    t_exp sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic t_if_ccip_c0_Rx rsp0(input logic [15:0] md, input logic [63:0] d);
        t_if_ccip_c0_Rx r;
        r = '0;
        r.hdr.mdata = md;
        r.data = d;
        r.rspValid = 1'b1;
        return r;
    endfunction

    function automatic t_if_ccip_c0_Rx mmio(input bit wr, input logic [15:0] a,
                                            input logic [8:0] tid, input logic [63:0] d);
        t_if_ccip_c0_Rx r;
        r = '0;
        r.hdr.addr = a;
        r.hdr.tid = tid;
        r.hdr.len = 2'd1;
        r.data = d;
        r.mmioWrValid = wr;
        r.mmioRdValid = !wr;
        return r;
    endfunction

    function automatic t_if_ccip_c1_Rx rsp1(input logic [15:0] md);
        t_if_ccip_c1_Rx r;
        r = '0;
        r.hdr.mdata = md;
        r.rspValid = 1'b1;
        return r;
    endfunction

    task automatic cmp_rx(input string tag, input int p, input t_if_ccip_Rx got,
                          input t_if_ccip_Rx exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s port %0d cyc %0d: got %h exp %h", tag, p, cyc, got, exp);
        end
    endtask

    task automatic cmp64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc %0d: got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_ports();
        t_if_ccip_Rx ea [N+1];
        t_if_ccip_Rx eb [N+1];
        t_exp keep[$];
        for (int p = 0; p <= N; p++) begin
            ea[p] = '0;
            eb[p] = '0;
        end
        foreach (sb[k]) begin
            if (sb[k].cyc == cyc) begin
                if (sb[k].dut == 0) begin
                    if (sb[k].ch) ea[sb[k].port].c1 = sb[k].c1;
                    else ea[sb[k].port].c0 = sb[k].c0;
                end else begin
                    if (sb[k].ch) eb[sb[k].port].c1 = sb[k].c1;
                    else eb[sb[k].port].c0 = sb[k].c0;
                end
            end else begin
                keep.push_back(sb[k]);
            end
        end
        sb = keep;
        for (int p = 0; p < N; p++) begin
            cmp_rx("dutA_afu", p, afu_a[p], ea[p]);
            cmp_rx("dutB_afu", p, afu_b[p], eb[p]);
        end
        cmp_rx("dutA_mgr", N, mgr_a, ea[N]);
        cmp_rx("dutB_mgr", N, mgr_b, eb[N]);
    endtask

    always @(negedge clk) begin
        if (chk_en) check_ports();
    end

    task automatic exp_c0(input int dut, input int port, input t_if_ccip_c0_Rx v);
        t_exp e;
        e.cyc = cyc + 3 + ((dut != 0) ? 2 : 0);
        e.dut = dut;
        e.port = port;
        e.ch = 1'b0;
        e.c0 = v;
        e.c1 = '0;
        sb.push_back(e);
    endtask

    task automatic exp_c1(input int port, input t_if_ccip_c1_Rx v);
        t_exp e;
        e.cyc = cyc + 3;
        e.dut = 0;
        e.port = port;
        e.ch = 1'b1;
        e.c0 = '0;
        e.c1 = v;
        sb.push_back(e);
    endtask

    task automatic pulse(input t_if_ccip_c0_Rx c0, input t_if_ccip_c1_Rx c1);
        up_a.c0 = c0;
        up_a.c1 = c1;
        @(negedge clk);
        up_a = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int p = 0; p < N; p++) begin
            cmp_rx(tag, p, afu_a[p], '0);
            cmp_rx(tag, p, afu_b[p], '0);
        end
        cmp_rx(tag, N, mgr_a, '0);
        cmp_rx(tag, N, mgr_b, '0);
        cmp64({tag, "_en"}, 64'(en_a), 64'hFF);
        cmp64({tag, "_drop"}, 64'(drop_a), 64'd0);
        cmp64({tag, "_off0"}, off_a[0], 64'd0);
        cmp64({tag, "_off7"}, off_a[7], 64'd0);
    endtask

    initial begin
        up_a = '0;
        up_b = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // c0 response to VM 1, VMID field cleared on delivery
        exp_c0(0, 1, rsp0(16'h1012, 64'hA5A5));
        pulse(rsp0(16'h3012, 64'hA5A5), '0);

        // deeper pipe, wide window: read lands on VM 2 five cycles later
        exp_c0(1, 2, mmio(1'b0, 16'h0005, 9'd3, 64'd0));
        up_b.c0 = mmio(1'b0, 16'h0305, 9'd3, 64'd0);
        @(negedge clk);
        up_b = '0;

        // control write offset[0]; visible two cycles after entry
        exp_c0(0, N, mmio(1'b1, 16'h0010, 9'd5, 64'hDEAD_0000));
        pulse(mmio(1'b1, 16'h0010, 9'd5, 64'hDEAD_0000), '0);
        cmp64("off0_early", off_a[0], 64'd0);
        @(negedge clk);
        cmp64("off0", off_a[0], 64'hDEAD_0000);

        exp_c0(0, N, mmio(1'b1, 16'h001E, 9'd6, 64'h0123_4567_89AB_CDEF));
        pulse(mmio(1'b1, 16'h001E, 9'd6, 64'h0123_4567_89AB_CDEF), '0);
        exp_c0(0, N, mmio(1'b1, 16'h0020, 9'd6, 64'h55));
        pulse(mmio(1'b1, 16'h0020, 9'd6, 64'h55), '0);
        @(negedge clk);
        cmp64("off7", off_a[7], 64'h0123_4567_89AB_CDEF);
        cmp64("off1_untouched", off_a[1], 64'd0);
        cmp64("off0_kept", off_a[0], 64'hDEAD_0000);

        // disable VM 1, then a c1 response to it is dropped
        exp_c0(0, N, mmio(1'b1, 16'h0008, 9'd9, 64'hFD));
        pulse(mmio(1'b1, 16'h0008, 9'd9, 64'hFD), '0);
        pulse('0, rsp1(16'h2034));
        @(negedge clk);
        cmp64("drop_1", 64'(drop_a), 64'd1);
        cmp64("en_fd", 64'(en_a), 64'hFD);

        exp_c0(0, N, mmio(1'b0, 16'h0080, 9'd7, 64'd0));
        pulse(mmio(1'b0, 16'h0080, 9'd7, 64'd0), '0);
        exp_c0(0, 0, mmio(1'b0, 16'h0003, 9'd8, 64'd0));
        pulse(mmio(1'b0, 16'h0043, 9'd8, 64'd0), '0);
        exp_c0(0, N, mmio(1'b0, 16'h0240, 9'd10, 64'd0));
        pulse(mmio(1'b0, 16'h0240, 9'd10, 64'd0), '0);
        pulse(mmio(1'b1, 16'h0081, 9'd11, 64'd1), '0);
        pulse(mmio(1'b1, 16'h0240, 9'd12, 64'd2), '0);
        @(negedge clk);
        cmp64("drop_3", 64'(drop_a), 64'd3);

        // re-enable in the same cycle as a c1 rsp: old mask applies
        exp_c0(0, N, mmio(1'b1, 16'h0008, 9'd13, 64'hFF));
        pulse(mmio(1'b1, 16'h0008, 9'd13, 64'hFF), rsp1(16'h2099));
        exp_c1(1, rsp1(16'h00AB));
        pulse('0, rsp1(16'h20AB));
        cmp64("drop_4", 64'(drop_a), 64'd4);
        cmp64("en_ff", 64'(en_a), 64'hFF);

        // c0 and c1 to VM 2 together
        exp_c0(0, 2, rsp0(16'h0055, 64'hBEEF));
        exp_c1(2, rsp1(16'h0777));
        pulse(rsp0(16'h4055, 64'hBEEF), rsp1(16'h4777));

        // disable VM 3; dual drop adds two
        exp_c0(0, N, mmio(1'b1, 16'h0008, 9'd14, 64'hF7));
        pulse(mmio(1'b1, 16'h0008, 9'd14, 64'hF7), '0);
        pulse(rsp0(16'h6001, 64'd0), rsp1(16'h6002));
        @(negedge clk);
        cmp64("drop_6", 64'(drop_a), 64'd6);

        // drop and clear in the same decode cycle: clear wins
        exp_c0(0, N, mmio(1'b1, 16'h000A, 9'd15, 64'd0));
        pulse(mmio(1'b1, 16'h000A, 9'd15, 64'd0), rsp1(16'h6003));
        cmp64("drop_pre_clr", 64'(drop_a), 64'd6);
        @(negedge clk);
        cmp64("drop_clr", 64'(drop_a), 64'd0);

        // saturation near the top of the counter
        force u_a.u_regs.drop_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release u_a.u_regs.drop_q;
        cmp64("drop_forced", 64'(drop_a), 64'hFFFF_FFFE);
        pulse(rsp0(16'h6004, 64'd0), rsp1(16'h6005));
        @(negedge clk);
        cmp64("drop_sat2", 64'(drop_a), 64'hFFFF_FFFF);
        pulse('0, rsp1(16'h6006));
        @(negedge clk);
        cmp64("drop_sat3", 64'(drop_a), 64'hFFFF_FFFF);

        // asynchronous reset with traffic in flight
        exp_c0(0, 0, rsp0(16'h0001, 64'h77));
        pulse(rsp0(16'h0001, 64'h77), '0);
        exp_c1(2, rsp1(16'h0001));
        pulse('0, rsp1(16'h4001));
        #2;
        chk_en = 1'b0;
        sb.delete();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        exp_c0(0, 5, rsp0(16'h0000, 64'h1234));
        pulse(rsp0(16'hA000, 64'h1234), '0);
        repeat (8) @(negedge clk);
        cmp64("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
